program_counter: RTL and testbench



---
 rtl/cpu_pkg.sv | 10 +
 rtl/program_counter.sv | 33 +++
 tb/tb_program_counter.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 6-bit CPU datapath.
package cpu_pkg;

  localparam int PC_WIDTH = 6;

  typedef logic [PC_WIDTH-1:0] pc_t;

  localparam pc_t PC_RESET = '0;

endpackage

// File: rtl/program_counter.sv
// Program counter register: captures the next-PC value every rising clk edge,
// asynchronously forced to the boot vector while reset is low.
module program_counter
  import cpu_pkg::*;
#(
  parameter int                WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(PC_RESET)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] r_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_VALUE;
    end else begin
      r_pc <= in;
    end
  end

  assign out = r_pc;

`ifndef SYNTHESIS
  // Boot vector must be visible at every edge seen while reset is held.
  a_reset_holds: assert property (@(posedge clk) !reset |-> out == RESET_VALUE)
    else $error("program_counter: out not at RESET_VALUE while reset low");
`endif

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed plan plus random traffic
// against a queue-based model of "out follows in one edge later, 0 in reset".
`timescale 1ns/1ps
module tb_program_counter;

  localparam int W = 6;

  logic         clk;
  logic         reset;
  logic [W-1:0] pc_in;
  logic [W-1:0] pc_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: value out must show now, and values due after upcoming edges.
  logic [W-1:0] cur;
  logic [W-1:0] exp_q[$];

  program_counter #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk  (clk),
    .reset(reset),
    .in   (pc_in),
    .out  (pc_out)
  );

  initial clk = 1'b0;
  always #100 clk = ~clk;

  function automatic void check(input string name, input logic [W-1:0] got,
                                input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at %0t: out=%0d expected=%0d", name, $time, got, want);
    end
  endfunction

  // Edge-side comparison: whatever was due for this edge must now be on out.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check("edge", pc_out, cur);
    end
  end

  // Drive one cycle's inputs midway between edges and check nothing moved
  // except via async reset.
  task automatic step(input logic [W-1:0] in_v, input logic rst_v);
    @(negedge clk);
    pc_in = in_v;
    reset = rst_v;
    #1;
    if (!rst_v) cur = '0;
    check("between_edges", pc_out, cur);
    exp_q.push_back(rst_v ? in_v : '0);
  endtask

  task automatic lit_after_edge(input string name, input logic [W-1:0] want);
    @(posedge clk);
    #2;
    check(name, pc_out, want);
  endtask

  initial begin
    cur   = '0;
    reset = 1'b0;
    pc_in = '0;

    // Reset held for the whole window; out pinned at 0 despite in=1 and edges.
    #10 pc_in = 6'd1;
    #10 check("hold_rst_20", pc_out, 6'd0);
    #1000 check("hold_rst_1020", pc_out, 6'd0);
    #200 check("hold_rst_1220", pc_out, 6'd0);

    // Release between edges: no change until the next edge, then capture 1.
    step(6'd1, 1'b0);
    step(6'd1, 1'b1);
    lit_after_edge("release_capture", 6'd1);
    step(6'd1, 1'b1);
    lit_after_edge("release_stable", 6'd1);

    // Successive captures including both boundary values.
    step(6'd5, 1'b1);
    lit_after_edge("seq_5", 6'd5);
    step(6'd6, 1'b1);
    lit_after_edge("seq_6", 6'd6);
    step(6'd63, 1'b1);
    lit_after_edge("seq_63", 6'd63);
    step(6'd0, 1'b1);
    lit_after_edge("seq_0", 6'd0);

    // Mid-cycle change of in has no effect until the following edge.
    step(6'd17, 1'b1);
    lit_after_edge("mid_17", 6'd17);
    step(6'd17, 1'b1);
    #49 pc_in = 6'd42;
    exp_q[exp_q.size()-1] = 6'd42;
    #1 check("mid_hold", pc_out, 6'd17);
    lit_after_edge("mid_42", 6'd42);

    // Async reset midway between edges with out=63, held for 3 edges.
    step(6'd63, 1'b1);
    lit_after_edge("pre_rst_63", 6'd63);
    step(6'd63, 1'b0);
    check("async_rst", pc_out, 6'd0);
    for (int i = 0; i < 3; i++) step(6'd63, 1'b0);

    // Release coincident with a rising edge: that edge is ignored. Released
    // with a nonblocking update so the flop sees the pre-edge (low) reset.
    step(6'd9, 1'b0);
    @(posedge clk);
    reset <= 1'b1;
    #2 check("coincident_ignored", pc_out, 6'd0);
    step(6'd9, 1'b1);
    lit_after_edge("coincident_next", 6'd9);

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      step(W'($urandom_range(0, 63)), ($urandom_range(0, 11) != 0));
    end

    repeat (2) @(posedge clk);
    #5;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
